// File: rtl/ysyx_23060187_idu_stage.sv
// ysyx_23060187_idu_stage: registered RV32 instruction-decode stage.
// Splits the instruction into register indices and function fields, builds the
// sign-extended immediate for every base format and flags illegal encodings.
// Optional macro YSYX_23060187_IDU_SKID_EN adds a skid entry so that in_ready
// is registered and carries no combinational path from out_ready.
module ysyx_23060187_idu_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_fun3,
  output logic                  out_fun7,
  output logic [2:0]            out_fmt,
  output logic [XLEN-1:0]       out_imm,
  output logic                  out_illegal
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
`ifdef YSYX_23060187_IDU_SKID_EN
  localparam logic [1:0] TWO   = 2'd2;
`endif

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [6:0]            opcode;
    logic [2:0]            fun3;
    logic                  fun7;
    logic [2:0]            fmt;
    logic [XLEN-1:0]       imm;
    logic                  illegal;
  } bundle_t;

  logic               [2:0]  w_fmt;
  logic signed        [31:0] w_imm32;
  logic                      w_use_rd;
  logic                      w_use_rs1;
  logic                      w_use_rs2;
  logic                      w_illegal;
  bundle_t                   w_dec;

  bundle_t                   r_main;
  logic               [1:0]  r_state;
  logic               [1:0]  w_state_nxt;
  logic                      w_acc;
  logic                      w_xfer;
  logic                      w_load_main;
`ifdef YSYX_23060187_IDU_SKID_EN
  bundle_t                   r_skid;
  logic                      r_in_ready;
  logic                      w_load_skid;
  logic                      w_main_from_skid;
`endif

  // Opcode to format map, immediate construction and register-use flags
  always_comb begin
    w_fmt     = FMT_NONE;
    w_imm32   = '0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (in_inst[6:0])
      7'b0110111, 7'b0010111: begin
        w_fmt    = FMT_U;
        w_imm32  = {in_inst[31:12], 12'b0};
        w_use_rd = 1'b1;
      end
      7'b1101111: begin
        w_fmt    = FMT_J;
        w_imm32  = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        w_use_rd = 1'b1;
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
        w_fmt     = FMT_I;
        w_imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      7'b1100011: begin
        w_fmt     = FMT_B;
        w_imm32   = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      7'b0100011: begin
        w_fmt     = FMT_S;
        w_imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      7'b0110011: begin
        w_fmt     = FMT_R;
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // Illegal flag: unknown opcode, or on RV32E any used index with bit 4 set
  always_comb begin
    w_illegal = (w_fmt == FMT_NONE);
    if (REG_ADDR_W == 4) begin
      w_illegal = w_illegal | (w_use_rd & in_inst[11]) | (w_use_rs1 & in_inst[19])
                | (w_use_rs2 & in_inst[24]);
    end
  end

  // Pack the decoded bundle for the output register
  always_comb begin
    w_dec         = '0;
    w_dec.pc      = in_pc;
    w_dec.rs1     = in_inst[15 +: REG_ADDR_W];
    w_dec.rs2     = in_inst[20 +: REG_ADDR_W];
    w_dec.rd      = in_inst[7 +: REG_ADDR_W];
    w_dec.opcode  = in_inst[6:0];
    w_dec.fun3    = in_inst[14:12];
    w_dec.fun7    = in_inst[30];
    w_dec.fmt     = w_fmt;
    w_dec.imm     = XLEN'(w_imm32);
    w_dec.illegal = w_illegal;
  end

  assign w_acc     = in_valid && in_ready;
  assign out_valid = (r_state != EMPTY);
  assign w_xfer    = out_valid && out_ready;

`ifdef YSYX_23060187_IDU_SKID_EN
  assign in_ready = r_in_ready && !rst;
`else
  assign in_ready = !rst && (!out_valid || out_ready);
`endif

  // Buffer next-state and load selects; flush overrides any accept
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
`ifdef YSYX_23060187_IDU_SKID_EN
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
`endif
    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_load_main = 1'b1;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_acc && w_xfer) begin
          w_load_main = 1'b1;
`ifdef YSYX_23060187_IDU_SKID_EN
        end else if (w_acc) begin
          w_load_skid = 1'b1;
          w_state_nxt = TWO;
`endif
        end else if (w_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
`ifdef YSYX_23060187_IDU_SKID_EN
      TWO: begin
        if (w_xfer) begin
          w_main_from_skid = 1'b1;
          w_state_nxt      = ONE;
        end
      end
`endif
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) begin
      w_state_nxt      = EMPTY;
      w_load_main      = 1'b0;
`ifdef YSYX_23060187_IDU_SKID_EN
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
`endif
    end
  end

  // State and data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= '0;
`ifdef YSYX_23060187_IDU_SKID_EN
      r_skid     <= '0;
      r_in_ready <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main) r_main <= w_dec;
`ifdef YSYX_23060187_IDU_SKID_EN
      if (w_main_from_skid) r_main <= r_skid;
      if (w_load_skid) r_skid <= w_dec;
      // in_ready is precomputed from the next state so it needs no out_ready path
      r_in_ready <= (w_state_nxt != TWO);
`endif
    end
  end

  assign out_pc      = r_main.pc;
  assign out_rs1     = r_main.rs1;
  assign out_rs2     = r_main.rs2;
  assign out_rd      = r_main.rd;
  assign out_opcode  = r_main.opcode;
  assign out_fun3    = r_main.fun3;
  assign out_fun7    = r_main.fun7;
  assign out_fmt     = r_main.fmt;
  assign out_imm     = r_main.imm;
  assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_ysyx_23060187_idu_stage.sv
// Testbench for ysyx_23060187_idu_stage: table-driven decode vectors plus
// hand-written reset, back-pressure, flush and skid sequences. A second
// instance with REG_ADDR_W=4 checks the RV32E index rule on the same stream.
module tb_ysyx_23060187_idu_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid, out_fun7, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_fun3, out_fmt;

  logic        e_in_ready, e_out_valid, e_fun7, e_illegal;
  logic [31:0] e_pc, e_imm;
  logic [3:0]  e_rs1, e_rs2, e_rd;
  logic [6:0]  e_opcode;
  logic [2:0]  e_fun3, e_fmt;

  always #5 clk = ~clk;

  ysyx_23060187_idu_stage #(.XLEN(32), .REG_ADDR_W(5)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_fun3(out_fun3), .out_fun7(out_fun7),
    .out_fmt(out_fmt), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  ysyx_23060187_idu_stage #(.XLEN(32), .REG_ADDR_W(4)) u_dut_e (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(e_out_valid), .out_ready(out_ready),
    .out_pc(e_pc), .out_rs1(e_rs1), .out_rs2(e_rs2), .out_rd(e_rd),
    .out_opcode(e_opcode), .out_fun3(e_fun3), .out_fun7(e_fun7),
    .out_fmt(e_fmt), .out_imm(e_imm), .out_illegal(e_illegal)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic        ill;
    logic        ill_e;
  } vec_t;

  vec_t vt[14];

  function automatic logic [31:0] bp_inst(input int k);
    logic [31:0] v;
    v = 32'(k + 1);
    return (v << 20) | (v << 7) | 32'h13;
  endfunction

  initial begin
    int          sent, rcv, occ;
    bit          prev_stall;
    logic        acc, xf;
    logic [31:0] held_pc, held_imm;
    bit          pat[4];

    //            inst          fmt   rd     rs1    rs2    f3    f7    imm            ill   ill_e
    vt[0]  = '{32'hFFF00093, 3'd1, 5'd1,  5'd0, 5'd31, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vt[1]  = '{32'h0020A423, 3'd2, 5'd8,  5'd1, 5'd2,  3'd2, 1'b0, 32'h00000008, 1'b0, 1'b0};
    vt[2]  = '{32'hFE000EE3, 3'd3, 5'd29, 5'd0, 5'd0,  3'd0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0};
    vt[3]  = '{32'h123452B7, 3'd4, 5'd5,  5'd8, 5'd3,  3'd5, 1'b0, 32'h12345000, 1'b0, 1'b0};
    vt[4]  = '{32'h00000000, 3'd7, 5'd0,  5'd0, 5'd0,  3'd0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vt[5]  = '{32'h01000093, 3'd1, 5'd1,  5'd0, 5'd16, 3'd0, 1'b0, 32'h00000010, 1'b0, 1'b0};
    vt[6]  = '{32'h00000893, 3'd1, 5'd17, 5'd0, 5'd0,  3'd0, 1'b0, 32'h00000000, 1'b0, 1'b1};
    vt[7]  = '{32'h00C000EF, 3'd5, 5'd1,  5'd0, 5'd12, 3'd0, 1'b0, 32'h0000000C, 1'b0, 1'b0};
    vt[8]  = '{32'h002081B3, 3'd0, 5'd3,  5'd1, 5'd2,  3'd0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vt[9]  = '{32'h402081B3, 3'd0, 5'd3,  5'd1, 5'd2,  3'd0, 1'b1, 32'h00000000, 1'b0, 1'b0};
    vt[10] = '{32'h00001517, 3'd4, 5'd10, 5'd0, 5'd0,  3'd1, 1'b0, 32'h00001000, 1'b0, 1'b0};
    vt[11] = '{32'hFE20AE23, 3'd2, 5'd28, 5'd1, 5'd2,  3'd2, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0};
    vt[12] = '{32'h0000007F, 3'd7, 5'd0,  5'd0, 5'd0,  3'd0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vt[13] = '{32'h01000033, 3'd0, 5'd0,  5'd0, 5'd16, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b1};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset held 3 cycles with in_valid asserted
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_inst = 32'hFFF00093; in_pc = 32'h0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_imm", out_imm, 0);
      chk("rst_e_in_ready", e_in_ready, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Decode table, back-to-back with out_ready=1
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      in_inst  = vt[i].inst;
      in_pc    = 32'h8000_0000 + 32'(4 * i);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_pc", i), out_pc, 32'h8000_0000 + 32'(4 * i));
      chk($sformatf("v%0d_fmt", i), out_fmt, vt[i].fmt);
      chk($sformatf("v%0d_rd", i), out_rd, vt[i].rd);
      chk($sformatf("v%0d_rs1", i), out_rs1, vt[i].rs1);
      chk($sformatf("v%0d_rs2", i), out_rs2, vt[i].rs2);
      chk($sformatf("v%0d_opcode", i), out_opcode, vt[i].inst & 32'h7F);
      chk($sformatf("v%0d_fun3", i), out_fun3, vt[i].f3);
      chk($sformatf("v%0d_fun7", i), out_fun7, vt[i].f7);
      chk($sformatf("v%0d_imm", i), out_imm, vt[i].imm);
      chk($sformatf("v%0d_illegal", i), out_illegal, vt[i].ill);
      chk($sformatf("v%0d_e_valid", i), e_out_valid, 1);
      chk($sformatf("v%0d_e_pc", i), e_pc, 32'h8000_0000 + 32'(4 * i));
      chk($sformatf("v%0d_e_illegal", i), e_illegal, vt[i].ill_e);
      chk($sformatf("v%0d_e_fmt", i), e_fmt, vt[i].fmt);
      chk($sformatf("v%0d_e_imm", i), e_imm, vt[i].imm);
      chk($sformatf("v%0d_e_rd", i), e_rd, vt[i].rd & 5'hF);
      chk($sformatf("v%0d_e_rs1", i), e_rs1, vt[i].rs1 & 5'hF);
      chk($sformatf("v%0d_e_rs2", i), e_rs2, vt[i].rs2 & 5'hF);
      chk($sformatf("v%0d_e_op", i), {e_opcode, e_fun3, e_fun7},
          {out_opcode, vt[i].f3, vt[i].f7});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("table_drain_valid", out_valid, 0);

    // Back-pressure: 8 instructions, out_ready pattern 1,0,0,1
    sent = 0; rcv = 0; prev_stall = 0; held_pc = '0; held_imm = '0;
    for (int cyc = 0; cyc < 200 && rcv < 8; cyc++) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      in_inst   = bp_inst(sent);
      in_pc     = 32'h2000 + 32'(4 * sent);
      @(negedge clk);
      occ = sent - rcv;
`ifdef YSYX_23060187_IDU_SKID_EN
      chk("bp_in_ready", in_ready, occ != 2);
`else
      chk("bp_in_ready", in_ready, (occ == 0) || out_ready);
`endif
      chk("bp_out_valid", out_valid, occ != 0);
      acc = in_valid && in_ready;
      xf  = out_valid && out_ready;
      if (prev_stall) begin
        chk("bp_stable_pc", out_pc, held_pc);
        chk("bp_stable_imm", out_imm, held_imm);
      end
      if (xf) begin
        chk("bp_order_pc", out_pc, 32'h2000 + 32'(4 * rcv));
        chk("bp_order_imm", out_imm, 32'(rcv + 1));
        chk("bp_order_rd", out_rd, 5'(rcv + 1));
        rcv++;
      end
      prev_stall = out_valid && !out_ready;
      held_pc    = out_pc;
      held_imm   = out_imm;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    chk("bp_received", rcv, 8);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_no_extra", out_valid, 0);

`ifdef YSYX_23060187_IDU_SKID_EN
    // TWO with out_ready=1 and in_valid=1: nothing accepted that cycle
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_inst = bp_inst(0); in_pc = 32'h3000;
    @(posedge clk); #1;
    in_inst = bp_inst(1); in_pc = 32'h3004;
    @(posedge clk); #1;
    in_inst = bp_inst(2); in_pc = 32'h3008; out_ready = 1'b1;
    @(negedge clk);
    chk("two_in_ready", in_ready, 0);
    chk("two_out_pc", out_pc, 32'h3000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("two_skid_on_out", out_pc, 32'h3004);
    chk("two_then_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("two_new_pc", out_pc, 32'h3008);
    chk("two_new_valid", out_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("two_drained", out_valid, 0);
`endif

    // Flush while stalled with entries held, together with a new input
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_inst = bp_inst(4); in_pc = 32'h4000;
    @(posedge clk); #1;
    in_inst = bp_inst(5); in_pc = 32'h4004;
    @(posedge clk); #1;
    in_inst = bp_inst(6); in_pc = 32'h4008; flush = 1'b1;
    @(negedge clk);
    chk("flush_pre_in_ready", in_ready, 0);
    chk("flush_pre_pc", out_pc, 32'h4000);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("flush_nothing_after", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
